data_bram: RTL and testbench

- Synchronous single-port data RAM sitting directly downstream of the data memory controller.
- Consumes the controller's BRAM interface: word address, write data, 4-bit byte write enable and enable. Returns read data one cycle later.
- WRITE_FIRST semantics: a write updates dout with the new merged word in the same access. The load-extension logic relies on this and has no bypass.
- After every reset, a hardware clear sequencer zeroes the array and reports busy. Simulation and FPGA therefore start from identical contents.

---
 rtl/data_bram.sv | 129 ++++++++++++
 tb/tb_data_bram.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/data_bram.sv
// Single-port WRITE_FIRST data RAM behind the data memory controller, with a
// post-reset zeroing sequencer. Define DATA_BRAM_OUTREG_EN for a 2-cycle read path.
module data_bram #(
  parameter int unsigned DEPTH          = 32,
  parameter int unsigned ADDR_W         = 5,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] bram_addr,
  input  logic [31:0] bram_din,
  input  logic [3:0]  bram_we,
  input  logic        bram_en,
  output logic [31:0] bram_dout,
  output logic        busy,
  output logic        addr_err
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = 4;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic [ADDR_W-1:0]   idx_c;
  logic [DATA_W-1:0]   rd_word_c;
  logic [DATA_W-1:0]   merged_c;
  logic                oob_c;
  logic                wr_en_c;
  logic [ADDR_W-1:0]   wr_idx_c;
  logic [DATA_W-1:0]   wr_word_c;

  logic [DATA_W-1:0]   dout_q;
  logic                addr_err_q;
  logic                busy_q;

  assign idx_c     = bram_addr[ADDR_W-1:0];
  assign rd_word_c = mem[idx_c];
  assign oob_c     = |bram_addr[31:ADDR_W];

  // Byte-lane merge of new data over the currently stored word
  always_comb begin
    merged_c = rd_word_c;
    for (int i = 0; i < int'(LANES); i++) begin
      if (bram_we[i]) merged_c[8*i +: 8] = bram_din[8*i +: 8];
    end
  end

  // Next-state and array write control
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_en_c   = 1'b0;
    wr_idx_c  = idx_c;
    wr_word_c = merged_c;
    case (state_q)
      ST_CLEAR: begin
        if (CLEAR_ON_RESET != 0) begin
          wr_en_c   = 1'b1;
          wr_idx_c  = cnt_q;
          wr_word_c = '0;
          cnt_d     = cnt_q + ADDR_W'(1);
          if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = ST_RUN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        wr_en_c = bram_en && (|bram_we);
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      cnt_q      <= '0;
      busy_q     <= 1'b1;
      dout_q     <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == ST_CLEAR);
      if (state_q == ST_RUN && bram_en) begin
        dout_q     <= merged_c;
        addr_err_q <= oob_c;
      end
    end
  end

  // Array has no reset; while reset is held only a zero lands in word 0,
  // which the clear sweep writes anyway.
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_idx_c] <= wr_word_c;
  end

  assign busy = busy_q;

`ifdef DATA_BRAM_OUTREG_EN
  logic [DATA_W-1:0] dout2_q;
  logic              addr_err2_q;

  // Optional output register stage, free-running
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout2_q     <= '0;
      addr_err2_q <= 1'b0;
    end else begin
      dout2_q     <= dout_q;
      addr_err2_q <= addr_err_q;
    end
  end

  assign bram_dout = dout2_q;
  assign addr_err  = addr_err2_q;
`else
  assign bram_dout = dout_q;
  assign addr_err  = addr_err_q;
`endif

endmodule

// File: tb/tb_data_bram.sv
// Randomized self-checking bench for data_bram against a word-array reference model.
module tb_data_bram;

  localparam int unsigned DEPTH  = 32;
  localparam int unsigned ADDR_W = 5;

  logic        clk;
  logic        reset;
  logic [31:0] bram_addr;
  logic [31:0] bram_din;
  logic [3:0]  bram_we;
  logic        bram_en;
  logic [31:0] bram_dout;
  logic        busy;
  logic        addr_err;

  data_bram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CLEAR_ON_RESET(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .bram_addr (bram_addr),
    .bram_din  (bram_din),
    .bram_we   (bram_we),
    .bram_en   (bram_en),
    .bram_dout (bram_dout),
    .busy      (busy),
    .addr_err  (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  logic [31:0] model_mem [DEPTH];
  int          clear_left;
  logic [31:0] exp_d1, exp_d2;
  logic        exp_e1, exp_e2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_dout();
`ifdef DATA_BRAM_OUTREG_EN
    return exp_d2;
`else
    return exp_d1;
`endif
  endfunction

  function automatic logic exp_err();
`ifdef DATA_BRAM_OUTREG_EN
    return exp_e2;
`else
    return exp_e1;
`endif
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".busy"}, 32'(busy), 32'(clear_left > 0));
    check({tag, ".dout"}, bram_dout, exp_dout());
    check({tag, ".err"},  32'(addr_err), 32'(exp_err()));
  endtask

  // One clock: drive, advance the model on the edge, check just after it
  task automatic step(input logic en, input logic [31:0] addr,
                      input logic [31:0] din, input logic [3:0] we, input string tag);
    int          a;
    logic [31:0] w;
    bram_en   = en;
    bram_addr = addr;
    bram_din  = din;
    bram_we   = we;
    @(posedge clk);
    exp_d2 = exp_d1;
    exp_e2 = exp_e1;
    if (clear_left > 0) begin
      clear_left--;
    end else if (en) begin
      a = int'(addr % DEPTH);
      w = model_mem[a];
      for (int i = 0; i < 4; i++)
        if (we[i]) w[8*i +: 8] = din[8*i +: 8];
      model_mem[a] = w;
      exp_d1 = w;
      exp_e1 = (addr / DEPTH) != 0;
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = 32'h0;
    clear_left = DEPTH;
    exp_d1 = '0; exp_d2 = '0; exp_e1 = 1'b0; exp_e2 = 1'b0;
    check_outputs("rst_async");
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_outputs("rst_hold");
  endtask

  task automatic run_clear();
    for (int i = 0; i < int'(DEPTH); i++)
      step(1'b1, $urandom, $urandom, 4'hF, "clear");
  endtask

  task automatic sweep_reads();
    for (int i = 0; i < int'(DEPTH); i++)
      step(1'b1, 32'(i), $urandom, 4'h0, "sweep");
  endtask

  logic [31:0] ra;

  initial begin
    reset = 1'b1; bram_en = 1'b0; bram_addr = '0; bram_din = '0; bram_we = '0;
    clear_left = DEPTH;
    exp_d1 = '0; exp_d2 = '0; exp_e1 = 1'b0; exp_e2 = 1'b0;
    #12;

    do_reset();
    run_clear();
    sweep_reads();

    // Full write then read-back, including output hold on idle
    step(1'b1, 32'd3, 32'hDEADBEEF, 4'hF, "wr3");
    step(1'b1, 32'd3, 32'h0, 4'h0, "rd3");
    step(1'b0, 32'd9, 32'hFFFFFFFF, 4'hF, "idle");
    step(1'b0, 32'd3, 32'h0, 4'h0, "idle");

    // Partial write merge
    step(1'b1, 32'd5, 32'h11223344, 4'hF, "wr5");
    step(1'b1, 32'd5, 32'h00AB0000, 4'b0100, "merge5");
    step(1'b1, 32'd5, 32'h0, 4'h0, "rd5");

    // Out-of-range alias and addr_err
    step(1'b1, 32'h00000025, 32'h0, 4'h0, "oob");
    step(1'b0, 32'h0, 32'h0, 4'h0, "oob_hold");
    step(1'b0, 32'h0, 32'h0, 4'h0, "oob_hold");
    step(1'b1, 32'd6, 32'h0, 4'h0, "inrange");
    step(1'b1, 32'd32, 32'hA5A5A5A5, 4'b0011, "wrap");
    step(1'b1, 32'd0, 32'h0, 4'h0, "wrap_rd");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      ra = {($urandom_range(0, 3) == 0) ? 27'($urandom) : 27'h0, 5'($urandom)};
      step(1'($urandom_range(0, 3) != 0), ra, $urandom, 4'($urandom), "rand");
    end

    // Reset in the middle of the clear sweep
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, $urandom, $urandom, 4'hF, "clear_a");
    do_reset();
    run_clear();

    // Reset during RUN wipes previous contents
    step(1'b1, 32'd7, 32'h1, 4'hF, "wr7");
    step(1'b1, 32'd7, 32'h0, 4'h0, "rd7");
    do_reset();
    run_clear();
    step(1'b1, 32'd7, 32'h0, 4'h0, "rd7_clr");
    sweep_reads();

    // Latency probe around a single write
    step(1'b1, 32'd2, 32'hCAFEF00D, 4'hF, "wr2");
    step(1'b0, 32'd2, 32'h0, 4'h0, "wr2_lat1");
    step(1'b0, 32'd2, 32'h0, 4'h0, "wr2_lat2");

    for (int n = 0; n < 200; n++) begin
      ra = {($urandom_range(0, 7) == 0) ? 27'($urandom) : 27'h0, 5'($urandom)};
      step(1'($urandom_range(0, 2) != 0), ra, $urandom, 4'($urandom), "rand2");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
